// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor.
// Uses a single full-adder stage built from NAND half adders.
// Operands are shifted through LSB first, one bit per clock.
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | waiting for start; captures operands on start
// RUN   | processing one bit per clock, LSB first
// DONE  | one-cycle done pulse, then back to IDLE
module serial_addsub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;

    // full adder from two NAND half adders plus carry OR
    logic ha1_n, ha1_s, ha1_c;
    logic ha2_n, ha2_s, ha2_c;
    logic fa_s, fa_c;

    assign ha1_n = ~(a_sh[0] & b_sh[0]);
    assign ha1_s = ~(~(a_sh[0] & ha1_n) & ~(b_sh[0] & ha1_n));
    assign ha1_c = ~ha1_n;
    assign ha2_n = ~(ha1_s & carry);
    assign ha2_s = ~(~(ha1_s & ha2_n) & ~(carry & ha2_n));
    assign ha2_c = ~ha2_n;
    assign fa_s  = ha2_s;
    assign fa_c  = ha1_c | ha2_c;

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // status outputs decoded from state
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // operand capture, bit-serial datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        // subtraction as a + ~b + 1: invert b, preload carry
                        b_sh  <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    res_sh <= {fa_s, res_sh[WIDTH-1:1]};
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    carry  <= fa_c;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        result <= {fa_s, res_sh[WIDTH-1:1]};
                        cout   <= fa_c;
                        // carry into MSB differs from carry out of MSB
                        ovf    <= fa_c ^ carry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed testbench for serial_addsub (WIDTH=4).
module tb_serial_addsub;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] result;

    int total = 0;
    int bad = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .a(a), .b(b), .busy(busy), .done(done),
        .result(result), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // full operation: start at E0, RUN for W cycles, done at E(W)
    task automatic do_op(input string tag, input logic s, input logic [W-1:0] va,
                         input logic [W-1:0] vb, input logic [W-1:0] prev,
                         input logic [W-1:0] er, input logic ec, input logic eo);
        @(negedge clk);
        start = 1'b1; sub = s; a = va; b = vb;
        @(posedge clk); #1;
        chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
        start = 1'b0;
        for (int i = 1; i < W; i++) begin
            @(posedge clk); #1;
            chk({tag, "_busy_run"}, 32'(busy), 32'd1);
            chk({tag, "_done_run"}, 32'(done), 32'd0);
            chk({tag, "_hold_run"}, 32'(result), 32'(prev));
        end
        @(posedge clk); #1;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'(er));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        @(posedge clk); #1;
        chk({tag, "_done_end"}, 32'(done), 32'd0);
        chk({tag, "_result_hold"}, 32'(result), 32'(er));
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("add_3_5",  1'b0, 4'd3,  4'd5, 4'd0,  4'd8,  1'b0, 1'b1);
        do_op("add_15_1", 1'b0, 4'd15, 4'd1, 4'd8,  4'd0,  1'b1, 1'b0);
        do_op("add_0_0",  1'b0, 4'd0,  4'd0, 4'd0,  4'd0,  1'b0, 1'b0);
        do_op("sub_5_3",  1'b1, 4'd5,  4'd3, 4'd0,  4'd2,  1'b1, 1'b0);
        do_op("sub_3_5",  1'b1, 4'd3,  4'd5, 4'd2,  4'd14, 1'b0, 1'b0);
        do_op("sub_8_1",  1'b1, 4'd8,  4'd1, 4'd14, 4'd7,  1'b1, 1'b1);
        do_op("sub_7_7",  1'b1, 4'd7,  4'd7, 4'd7,  4'd0,  1'b1, 1'b0);

        // start while busy is ignored; operand changes mid-RUN have no effect
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 4'd2; b = 4'd2;
        @(posedge clk); #1;              // E0
        start = 1'b0;
        @(posedge clk); #1;              // E1
        @(negedge clk);
        start = 1'b1; a = 4'd9; b = 4'd9; sub = 1'b1;
        @(posedge clk); #1;              // E2
        start = 1'b0; a = 4'd15; b = 4'd15;
        chk("ign_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;              // E3
        chk("ign_done_early", 32'(done), 32'd0);
        @(posedge clk); #1;              // E4
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_result", 32'(result), 32'd4);
        chk("ign_cout", 32'(cout), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("ign_no_second_done", 32'(done), 32'd0);
            chk("ign_no_second_busy", 32'(busy), 32'd0);
            chk("ign_result_hold", 32'(result), 32'd4);
        end

        // asynchronous reset mid-RUN
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 4'd6; b = 4'd7;
        @(posedge clk); #1;              // E0
        start = 1'b0;
        @(posedge clk); #1;              // E1
        @(posedge clk); #1;              // E2
        chk("ar_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_result", 32'(result), 32'd0);
        chk("ar_cout", 32'(cout), 32'd0);
        chk("ar_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("ar_no_done", 32'(done), 32'd0);
            chk("ar_no_busy", 32'(busy), 32'd0);
        end
        do_op("add_6_7", 1'b0, 4'd6, 4'd7, 4'd0, 4'd13, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // watchdog
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
